// File: rtl/cartridge_flash_arbiter_if.sv
// Requester, flash and status signals of the cartridge flash arbiter.
// slave = arbiter side, master = requesters plus flash device side.
interface cartridge_flash_arbiter_if;
  logic        cpu_req;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_ack;
  logic        dma_req;
  logic [23:0] dma_addr;
  logic [15:0] dma_data;
  logic        dma_ack;
  logic [15:0] flash_data;
  logic [23:0] flash_addr;
  logic        flash_ce_l;
  logic        flash_oe_l;
  logic        addr_valid_l;
  logic        flash_we_l;
  logic        flash_clk;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_addr, dma_req, dma_addr, flash_data,
    output cpu_data, cpu_ack, dma_data, dma_ack, flash_addr,
           flash_ce_l, flash_oe_l, addr_valid_l, flash_we_l, flash_clk, busy
  );

  modport master (
    output cpu_req, cpu_addr, dma_req, dma_addr, flash_data,
    input  cpu_data, cpu_ack, dma_data, dma_ack, flash_addr,
           flash_ce_l, flash_oe_l, addr_valid_l, flash_we_l, flash_clk, busy
  );
endinterface

// File: rtl/cartridge_flash_arbiter.sv
// Two-requester (CPU, DMA) round-robin arbiter for an asynchronous-read NOR flash.
// One read per grant: IDLE -> SETUP -> WAIT x WAIT_CYCLES -> CAPTURE (ack) -> IDLE.
module cartridge_flash_arbiter #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  cartridge_flash_arbiter_if.slave   bus
);
  localparam int NUM_PORTS = 2;  // port 0 = CPU, port 1 = DMA
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, CAPTURE} state_t;

  state_t                              state, state_nxt;
  logic [3:0]                          cnt;
  logic                                last_dma;
  logic                                grant_dma;
  logic                                win_dma;
  logic [23:0]                         addr;
  logic                                ce_l, oe_l, av_l;
  logic [NUM_PORTS-1:0]                req, gsel, cap_en, ack;
  logic [NUM_PORTS-1:0][23:0]          req_addr;
  logic [NUM_PORTS-1:0][15:0]          data;

  assign req      = {bus.dma_req, bus.cpu_req};
  assign req_addr = {bus.dma_addr, bus.cpu_addr};
  // On a tie the requester that did not win last time gets the flash.
  assign win_dma  = req[1] & (~req[0] | ~last_dma);
  assign gsel     = {grant_dma, ~grant_dma};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ce_l      = 1'b1;
    oe_l      = 1'b1;
    av_l      = 1'b1;
    unique case (state)
      IDLE:    if (|req) state_nxt = SETUP;
      SETUP: begin
        ce_l      = 1'b0;
        av_l      = 1'b0;
        state_nxt = WAIT;
      end
      WAIT: begin
        ce_l = 1'b0;
        oe_l = 1'b0;
        if (cnt == '0) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      last_dma  <= 1'b1;
      grant_dma <= 1'b0;
      addr      <= '0;
    end else begin
      unique case (state)
        IDLE: if (|req) begin
          grant_dma <= win_dma;
          last_dma  <= win_dma;
          addr      <= req_addr[win_dma];
        end
        SETUP:   cnt <= CNT_INIT;
        WAIT:    if (cnt != '0) cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Per-requester data register; only the granted one loads on the last WAIT cycle.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign cap_en[i] = (state == WAIT) && (cnt == '0) && gsel[i];
    assign ack[i]    = (state == CAPTURE) && gsel[i];

    always_ff @(posedge clk) begin
      if (rst)            data[i] <= '0;
      else if (cap_en[i]) data[i] <= bus.flash_data;
    end
  end

  assign bus.cpu_data     = data[0];
  assign bus.dma_data     = data[1];
  assign bus.cpu_ack      = ack[0];
  assign bus.dma_ack      = ack[1];
  assign bus.flash_addr   = addr;
  assign bus.flash_ce_l   = ce_l;
  assign bus.flash_oe_l   = oe_l;
  assign bus.addr_valid_l = av_l;
  assign bus.flash_we_l   = 1'b1;
  assign bus.flash_clk    = 1'b1;
  assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_cartridge_flash_arbiter.sv
// Bench for cartridge_flash_arbiter: a WAIT_CYCLES=4 and a WAIT_CYCLES=1 instance share stimulus;
// a transaction-level model queues expected grants, a monitor checks every cycle against them.
module tb_cartridge_flash_arbiter;
  localparam int NK = 2;

  typedef struct {
    int          k;
    logic        dma;
    logic [23:0] addr;
    int          g;
  } txn_t;

  function automatic int wc(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Flash contents: 0x004123 reads as 0xBEEF.
  function automatic logic [15:0] fval(logic [23:0] a);
    return a[15:0] ^ 16'hFFCC ^ {8'h00, a[23:16]};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req, dma_req;
  logic [23:0] cpu_addr, dma_addr;
  int          cyc = 0;
  int          nvec = 0;
  int          nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  cartridge_flash_arbiter_if bus4();
  cartridge_flash_arbiter_if bus1();

  cartridge_flash_arbiter #(.WAIT_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  cartridge_flash_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus4.cpu_req    = cpu_req;
  assign bus4.cpu_addr   = cpu_addr;
  assign bus4.dma_req    = dma_req;
  assign bus4.dma_addr   = dma_addr;
  assign bus4.flash_data = fval(bus4.flash_addr);
  assign bus1.cpu_req    = cpu_req;
  assign bus1.cpu_addr   = cpu_addr;
  assign bus1.dma_req    = dma_req;
  assign bus1.dma_addr   = dma_addr;
  assign bus1.flash_data = fval(bus1.flash_addr);

  logic [NK-1:0]       o_cack, o_dack, o_ce, o_oe, o_av, o_we, o_fclk, o_busy;
  logic [NK-1:0][15:0] o_cdat, o_ddat;
  logic [NK-1:0][23:0] o_faddr;

  assign o_cack  = {bus1.cpu_ack,      bus4.cpu_ack};
  assign o_dack  = {bus1.dma_ack,      bus4.dma_ack};
  assign o_ce    = {bus1.flash_ce_l,   bus4.flash_ce_l};
  assign o_oe    = {bus1.flash_oe_l,   bus4.flash_oe_l};
  assign o_av    = {bus1.addr_valid_l, bus4.addr_valid_l};
  assign o_we    = {bus1.flash_we_l,   bus4.flash_we_l};
  assign o_fclk  = {bus1.flash_clk,    bus4.flash_clk};
  assign o_busy  = {bus1.busy,         bus4.busy};
  assign o_cdat  = {bus1.cpu_data,     bus4.cpu_data};
  assign o_ddat  = {bus1.dma_data,     bus4.dma_data};
  assign o_faddr = {bus1.flash_addr,   bus4.flash_addr};

  txn_t                sbq[$];
  logic [NK-1:0]       last_dma;
  int                  next_free [NK];
  logic [NK-1:0][15:0] ecpu, edma;

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (WAIT_CYCLES=%0d) cycle %0d: got %0h expected %0h", nm, wc(k), cyc, act, exp);
    end
  endtask

  // Reference model: a grant taken in cycle g acks in g+W+2 and frees the arbiter at g+W+3.
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < NK; k++) begin
      if (rst) begin
        for (int j = sbq.size() - 1; j >= 0; j--)
          if (sbq[j].k == k) sbq.delete(j);
        last_dma[k]  = 1'b1;
        next_free[k] = cyc + 1;
        ecpu[k]      = '0;
        edma[k]      = '0;
      end else begin
        for (int j = 0; j < sbq.size(); j++)
          if (sbq[j].k == k && cyc == sbq[j].g + wc(k) + 1) begin
            if (sbq[j].dma) edma[k] = fval(sbq[j].addr);
            else            ecpu[k] = fval(sbq[j].addr);
          end
        if (cyc >= next_free[k] && (cpu_req || dma_req)) begin
          txn_t t;
          t.k          = k;
          t.dma        = dma_req && (!cpu_req || !last_dma[k]);
          t.addr       = t.dma ? dma_addr : cpu_addr;
          t.g          = cyc;
          last_dma[k]  = t.dma;
          next_free[k] = cyc + wc(k) + 3;
          sbq.push_back(t);
        end
      end
    end
  end

  // Monitor: derive the expected phase from the oldest queued grant and compare all outputs.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      int          idx;
      int          rel;
      logic        stp, wt, cap, dmag;
      logic [23:0] ea;
      idx  = -1;
      stp  = 1'b0;
      wt   = 1'b0;
      cap  = 1'b0;
      dmag = 1'b0;
      ea   = '0;
      for (int j = 0; j < sbq.size(); j++)
        if (idx < 0 && sbq[j].k == k) idx = j;
      if (idx >= 0) begin
        rel  = cyc - sbq[idx].g;
        stp  = (rel == 1);
        wt   = (rel >= 2) && (rel <= wc(k) + 1);
        cap  = (rel == wc(k) + 2);
        dmag = sbq[idx].dma;
        ea   = sbq[idx].addr;
      end
      chk("busy",         k, 32'(o_busy[k]), 32'(stp | wt | cap));
      chk("ce_l",         k, 32'(o_ce[k]),   32'(!(stp | wt)));
      chk("oe_l",         k, 32'(o_oe[k]),   32'(!wt));
      chk("addr_valid_l", k, 32'(o_av[k]),   32'(!stp));
      chk("we_l",         k, 32'(o_we[k]),   32'd1);
      chk("flash_clk",    k, 32'(o_fclk[k]), 32'd1);
      chk("cpu_ack",      k, 32'(o_cack[k]), 32'(cap & !dmag));
      chk("dma_ack",      k, 32'(o_dack[k]), 32'(cap & dmag));
      if (stp) chk("flash_addr", k, 32'(o_faddr[k]), 32'(ea));
      if (cap) begin
        chk("ack_data", k, 32'(dmag ? o_ddat[k] : o_cdat[k]), 32'(fval(ea)));
        sbq.delete(idx);
      end
      chk("cpu_data", k, 32'(o_cdat[k]), 32'(ecpu[k]));
      chk("dma_data", k, 32'(o_ddat[k]), 32'(edma[k]));
    end
  end

  task automatic drive(logic r, logic c, logic d, int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst     = r;
      cpu_req = c;
      dma_req = d;
    end
  endtask

  initial begin
    rst      = 1'b1;
    cpu_req  = 1'b0;
    dma_req  = 1'b0;
    cpu_addr = '0;
    dma_addr = 24'h000777;
    drive(1, 0, 0, 3);
    // CPU-only read of 0x004123
    cpu_addr = 24'h004123;
    drive(0, 1, 0, 7);
    drive(0, 0, 0, 3);
    // same-cycle ties, then both held for a long alternating run
    cpu_addr = 24'h012340;
    dma_addr = 24'h5A0010;
    drive(0, 1, 1, 13);
    drive(0, 0, 0, 2);
    drive(0, 1, 1, 13);
    drive(0, 0, 0, 2);
    drive(0, 1, 1, 60);
    drive(0, 0, 0, 8);
    // DMA drops its request during WAIT
    drive(0, 0, 1, 3);
    drive(0, 0, 0, 8);
    // reset in the middle of a CPU read, then a clean CPU read
    drive(0, 1, 0, 4);
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 8);
    drive(0, 0, 0, 4);
    repeat (2500) begin
      @(posedge clk);
      #1;
      rst     = ($urandom_range(0, 199) == 0);
      cpu_req = ($urandom_range(0, 3) != 0);
      dma_req = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) cpu_addr = 24'($urandom);
      if ($urandom_range(0, 3) == 0) dma_addr = 24'($urandom);
    end
    drive(0, 0, 0, 12);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cartridge_flash_arbiter.md
CARTRIDGE_FLASH_ARBITER -- requirements
Module: cartridge_flash_arbiter

Interface
REQ-001 The block SHALL have one parameter: WAIT_CYCLES, default 4, number of flash access cycles before data capture; legal range 1..15.
REQ-002 I_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-003 I_RESET  in  1  synchronous, active-high reset.
REQ-004 I_CPU_REQ  in  1  CPU-side read request; level, held until O_CPU_ACK.
REQ-005 I_CPU_ADDR  in  24  CPU-side flash word address; stable while I_CPU_REQ is high.
REQ-006 O_CPU_DATA  out  16  last flash word captured for the CPU.
REQ-007 O_CPU_ACK  out  1  one-cycle pulse; O_CPU_DATA is valid from this cycle on.
REQ-008 I_DMA_REQ, I_DMA_ADDR[23:0], O_DMA_DATA[15:0], O_DMA_ACK SHALL mirror REQ-004..007 for the loader/DMA requester.
REQ-009 I_FLASH_DATA  in  16  flash read data bus.
REQ-010 O_FLASH_ADDR  out  24  registered flash address.
REQ-011 O_FLASH_CE_L, O_FLASH_OE_L, O_ADDR_VALID_L  out  1 each  active-low flash strobes.
REQ-012 O_FLASH_WE_L  out  1  constant 1; O_FLASH_CLK  out  1  constant 1 (asynchronous read mode).
REQ-013 O_BUSY  out  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, WAIT, CAPTURE; all outputs registered or decoded from state only.
REQ-015 IDLE: if any request is high, latch grant and address into O_FLASH_ADDR and go to SETUP; else stay.
REQ-016 Arbitration: a single requester is granted; if both are high in the same IDLE cycle, grant the requester not granted last (round-robin); the last-grant flag resets to DMA so the CPU wins the first tie.
REQ-017 SETUP (1 cycle): CE_L=0, ADDR_VALID_L=0, OE_L=1; load wait counter with WAIT_CYCLES-1; go to WAIT.
REQ-018 WAIT: CE_L=0, OE_L=0, ADDR_VALID_L=1; decrement counter; on the cycle the counter reads 0, capture I_FLASH_DATA into the granted requester's data register and go to CAPTURE.
REQ-019 CAPTURE (1 cycle): assert the granted requester's ACK only; CE_L=1, OE_L=1; go to IDLE unconditionally.
REQ-020 Latency: request sampled in IDLE at cycle 0 SHALL yield ACK high in cycle WAIT_CYCLES+2 (cycle 6 for the default).
REQ-021 Throughput: back-to-back requests SHALL see one IDLE turnaround cycle; a new SETUP no sooner than cycle WAIT_CYCLES+4.
REQ-022 The non-granted requester's data register and ACK SHALL not change during a transaction.
REQ-023 A request deasserted mid-transaction SHALL not abort it; the transaction completes and ACK still pulses.
REQ-024 A request arriving while O_BUSY is high SHALL wait and be considered at the next IDLE cycle.
REQ-025 Address changes on the requester side after grant SHALL not affect O_FLASH_ADDR until the next IDLE grant.
REQ-026 ACK outputs SHALL never be high for more than one consecutive cycle, and never both at once.

Reset
REQ-027 On I_RESET high at a clock edge: state=IDLE, counter=0, last-grant=DMA, O_FLASH_ADDR=0, O_CPU_DATA=O_DMA_DATA=0, both ACKs=0, O_BUSY=0, CE_L=OE_L=ADDR_VALID_L=1.
REQ-028 Reset asserted in any state SHALL abort the transaction with no ACK issued; the first request after reset is granted in the first IDLE cycle.

Verification
REQ-029 CPU-only read, I_CPU_ADDR=0x004123, flash returns 0xBEEF -> O_FLASH_ADDR=0x004123 in SETUP, O_CPU_ACK one pulse at cycle 6, O_CPU_DATA=0xBEEF, O_DMA_ACK stays 0.
REQ-030 CPU and DMA requests raised in the same cycle after reset -> CPU served first (ACK at cycle 6), DMA SETUP at cycle 8, DMA ACK at cycle 13; tie repeated afterwards -> DMA then CPU.
REQ-031 Both requesters held high for 6 transactions -> grants alternate C,D,C,D,C,D; no ACK overlap.
REQ-032 DMA drops I_DMA_REQ during WAIT -> O_DMA_ACK still pulses, O_DMA_DATA updated, then IDLE.
REQ-033 I_RESET pulsed in WAIT -> next cycle IDLE, all strobes high, no ACK; subsequent CPU request completes with normal latency.
REQ-034 WAIT_CYCLES=1 build -> ACK at cycle 3, OE_L low for exactly one cycle.
